// File: rtl/lb_sched_pkg.sv
// Shared definitions for the loopback tester scheduler: FSM states,
// register word addresses and CTRL/STATUS bit positions.
package lb_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ARM,
        ST_RUN,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_CH_EN   = 3'd1;
    localparam logic [2:0] ADDR_LOOPS   = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_CH_FAIL = 3'd4;
    localparam logic [2:0] ADDR_ERR_SEL = 3'd5;
    localparam logic [2:0] ADDR_ERR_MAP = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_FAIL      = 2;
    localparam int STAT_CH_LSB    = 8;
    localparam int STAT_SWEEP_LSB = 16;

endpackage

// File: rtl/terasic_loopback_sched_if.sv
// Avalon-MM slave bus between the interconnect and the scheduler.
interface terasic_loopback_sched_if;
    logic        s_cs;
    logic        s_read;
    logic        s_write;
    logic [2:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    modport master (
        output s_cs, s_read, s_write, s_address, s_writedata,
        input  s_readdata
    );

    modport slave (
        input  s_cs, s_read, s_write, s_address, s_writedata,
        output s_readdata
    );
endinterface

// File: rtl/lb_sched_next_ch.sv
// Priority finder: lowest enabled channel index at or above ptr.
module lb_sched_next_ch #(
    parameter int CH_NUM = 2
) (
    input  logic [CH_NUM-1:0] ch_en,
    input  logic [3:0]        ptr,
    output logic [3:0]        next_ch,
    output logic              found
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (ch_en[i] && (4'(i) >= ptr)) begin
                next_ch = 4'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/terasic_loopback_sched.sv
// Loopback tester scheduler: runs one tester channel at a time, repeats the
// sweep LOOPS times and keeps sticky per-pair failure maps.
// Optional feature macro: LB_SCHED_IRQ_EN adds the irq port and CTRL bit3.
module terasic_loopback_sched
    import lb_sched_pkg::*;
#(
    parameter int CH_NUM     = 2,
    parameter int PAIR_NUM   = 32,
    parameter int RUN_CYCLES = 4 * PAIR_NUM + 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    terasic_loopback_sched_if.slave    bus,
    output logic [CH_NUM-1:0]          lb_test_reset_n,
    input  logic [CH_NUM*PAIR_NUM-1:0] lb_error
`ifdef LB_SCHED_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int CNT_W = (RUN_CYCLES < 2) ? 2 : $clog2(RUN_CYCLES + 1);

    state_t                           state;
    logic [3:0]                       ptr;
    logic [15:0]                      sweeps;
    logic [15:0]                      loops_run;
    logic [CNT_W-1:0]                 cnt;
    logic                             busy;
    logic                             done;
    logic                             fail;
    logic [CH_NUM-1:0][PAIR_NUM-1:0]  err_map;
    logic [CH_NUM-1:0]                ch_en;
    logic [15:0]                      loops;
    logic [2:0]                       err_sel;
    logic [31:0]                      rd_mux;
    logic [PAIR_NUM-1:0]              cur_slice;
    logic [CH_NUM-1:0]                ptr_onehot;
    logic [3:0]                       next_ch;
    logic                             found;
    logic [15:0]                      sweeps_inc;
    logic                             wr;
    logic                             start_req;
    logic                             abort_req;
    logic                             clear_req;
    logic                             unused_wd;
`ifdef LB_SCHED_IRQ_EN
    logic                             irq_pend;
    logic                             irq_en;
`endif

    assign wr         = bus.s_cs & bus.s_write;
    assign start_req  = wr && (bus.s_address == ADDR_CTRL) && bus.s_writedata[CTRL_START];
    assign abort_req  = wr && (bus.s_address == ADDR_CTRL) && bus.s_writedata[CTRL_ABORT];
    assign clear_req  = wr && (bus.s_address == ADDR_CTRL) && bus.s_writedata[CTRL_CLEAR];
    assign sweeps_inc = (sweeps == 16'hFFFF) ? sweeps : sweeps + 16'd1;
    assign unused_wd  = ^bus.s_writedata;

    lb_sched_next_ch #(.CH_NUM(CH_NUM)) u_next_ch (
        .ch_en   (ch_en),
        .ptr     (ptr),
        .next_ch (next_ch),
        .found   (found)
    );

    // Error slice and run-enable bit of the channel under the pointer.
    always_comb begin
        cur_slice  = '0;
        ptr_onehot = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ptr == 4'(c)) begin
                cur_slice     = lb_error[c*PAIR_NUM +: PAIR_NUM];
                ptr_onehot[c] = 1'b1;
            end
        end
    end

    // Software-owned configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_en   <= '0;
            loops   <= 16'd1;
            err_sel <= '0;
`ifdef LB_SCHED_IRQ_EN
            irq_en  <= 1'b0;
`endif
        end else if (wr) begin
            case (bus.s_address)
                ADDR_CH_EN:   ch_en   <= bus.s_writedata[CH_NUM-1:0];
                ADDR_LOOPS:   loops   <= bus.s_writedata[15:0];
                ADDR_ERR_SEL: err_sel <= bus.s_writedata[2:0];
`ifdef LB_SCHED_IRQ_EN
                ADDR_CTRL:    irq_en  <= bus.s_writedata[CTRL_IRQ_EN];
`endif
                default: ;
            endcase
        end
    end

    // Sequencer FSM with status flags and sticky maps; clear is applied
    // before the state case so a combined clear+start clears first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            sweeps          <= '0;
            loops_run       <= 16'd1;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fail            <= 1'b0;
            err_map         <= '0;
            lb_test_reset_n <= '0;
`ifdef LB_SCHED_IRQ_EN
            irq_pend        <= 1'b0;
`endif
        end else begin
            if (clear_req) begin
                done    <= 1'b0;
                fail    <= 1'b0;
                err_map <= '0;
            end
`ifdef LB_SCHED_IRQ_EN
            if (clear_req || start_req) irq_pend <= 1'b0;
`endif
            if (abort_req) begin
                state           <= ST_IDLE;
                busy            <= 1'b0;
                done            <= 1'b0;
                lb_test_reset_n <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_req) begin
                            if (|ch_en) begin
                                sweeps    <= '0;
                                ptr       <= '0;
                                done      <= 1'b0;
                                busy      <= 1'b1;
                                loops_run <= (loops == 16'd0) ? 16'd1 : loops;
                                state     <= ST_SELECT;
                            end else begin
                                done     <= 1'b1;
                                fail     <= 1'b0;
`ifdef LB_SCHED_IRQ_EN
                                irq_pend <= 1'b1;
`endif
                                state    <= ST_DONE;
                            end
                        end
                    end
                    ST_SELECT: begin
                        if (found) begin
                            ptr   <= next_ch;
                            cnt   <= CNT_W'(1);
                            state <= ST_ARM;
                        end else begin
                            sweeps <= sweeps_inc;
                            if (sweeps_inc == loops_run) begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
`ifdef LB_SCHED_IRQ_EN
                                irq_pend <= 1'b1;
`endif
                                state    <= ST_DONE;
                            end else begin
                                ptr <= '0;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (cnt == '0) begin
                            cnt             <= CNT_W'(RUN_CYCLES - 1);
                            lb_test_reset_n <= ptr_onehot;
                            state           <= ST_RUN;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (cnt == '0) begin
                            lb_test_reset_n <= '0;
                            state           <= ST_CAPTURE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        for (int c = 0; c < CH_NUM; c++) begin
                            if (ptr == 4'(c)) err_map[c] <= err_map[c] | cur_slice;
                        end
                        if (|cur_slice) fail <= 1'b1;
                        lb_test_reset_n <= '0;
                        ptr             <= ptr + 4'd1;
                        state           <= ST_SELECT;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux = '0;
        case (bus.s_address)
`ifdef LB_SCHED_IRQ_EN
            ADDR_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
            ADDR_CH_EN:   rd_mux[CH_NUM-1:0] = ch_en;
            ADDR_LOOPS:   rd_mux[15:0] = loops;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]              = busy;
                rd_mux[STAT_DONE]              = done;
                rd_mux[STAT_FAIL]              = fail;
                rd_mux[STAT_CH_LSB +: 3]       = ptr[2:0];
                rd_mux[STAT_SWEEP_LSB +: 16]   = sweeps;
            end
            ADDR_CH_FAIL: begin
                for (int c = 0; c < CH_NUM; c++) rd_mux[c] = |err_map[c];
            end
            ADDR_ERR_SEL: rd_mux[2:0] = err_sel;
            ADDR_ERR_MAP: begin
                for (int c = 0; c < CH_NUM; c++) begin
                    if (err_sel == 3'(c)) rd_mux[PAIR_NUM-1:0] = err_map[c];
                end
            end
            default: ;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.s_readdata <= '0;
        end else if (bus.s_cs && bus.s_read) begin
            bus.s_readdata <= rd_mux;
        end
    end

`ifdef LB_SCHED_IRQ_EN
    assign irq = irq_pend & irq_en;
`endif

endmodule

// File: tb/tb_terasic_loopback_sched.sv
// Self-checking bench for terasic_loopback_sched: a schedule model predicts
// lb_test_reset_n on every cycle; register reads pin status and maps.
module tb_terasic_loopback_sched;
    import lb_sched_pkg::*;

    localparam int CH_NUM   = 2;
    localparam int PAIR_NUM = 32;
    localparam int R        = 4 * PAIR_NUM + 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    terasic_loopback_sched_if bus ();
    logic [CH_NUM-1:0]          lb;
    logic [CH_NUM*PAIR_NUM-1:0] lb_error;
`ifdef LB_SCHED_IRQ_EN
    logic irq;
`endif

    terasic_loopback_sched #(.CH_NUM(CH_NUM), .PAIR_NUM(PAIR_NUM), .RUN_CYCLES(R)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .lb_test_reset_n (lb),
        .lb_error        (lb_error)
`ifdef LB_SCHED_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int t0     = 0;
    int stop_k = 1 << 30;
    bit m_on   = 1'b0;
    bit err_on = 1'b0;
    int m_ch[$];
    int m_loops = 1;
    int err_k;
    logic [31:0] rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int k_now();
        return cyc - t0 + 1;
    endfunction

    function automatic int sweep_len();
        return m_ch.size() * (4 + R) + 1;
    endfunction

    // Expected run enables k cycles after the start write was sampled.
    function automatic logic [CH_NUM-1:0] exp_lb(input int k);
        logic [CH_NUM-1:0] v;
        int off, slot, pos;
        v = '0;
        if (m_ch.size() == 0 || k < 1 || k >= stop_k || k > m_loops * sweep_len()) return v;
        off  = (k - 1) % sweep_len();
        slot = off / (4 + R);
        pos  = off % (4 + R);
        if (slot < m_ch.size() && pos >= 3 && pos < 3 + R) v[m_ch[slot]] = 1'b1;
        return v;
    endfunction

    // Per-cycle compare of the run enables against the schedule model.
    always @(negedge clk) begin
        if (m_on) begin
            check("lb_sched", 32'(lb), 32'(exp_lb(k_now())));
            check("lb_onehot", 32'($countones(lb) <= 1), 32'd1);
        end
    end

    // Error injection on channel 1 during the second sweep only.
    always @(negedge clk) begin
        lb_error = '0;
        if (err_on && m_on) begin
            err_k = k_now();
            if (err_k > sweep_len() && err_k <= 2 * sweep_len())
                lb_error[PAIR_NUM +: PAIR_NUM] = 32'h0000_0100;
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input bit mark);
        bus.s_cs = 1'b1; bus.s_write = 1'b1; bus.s_address = a; bus.s_writedata = d;
        @(posedge clk); #1;
        if (mark) begin
            t0 = cyc; stop_k = 1 << 30; m_on = 1'b1;
        end
        bus.s_cs = 1'b0; bus.s_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.s_cs = 1'b1; bus.s_read = 1'b1; bus.s_address = a;
        @(posedge clk); #1;
        bus.s_cs = 1'b0; bus.s_read = 1'b0;
        @(negedge clk);
        d = bus.s_readdata;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a,
                             input logic [31:0] exp, input logic [31:0] mask);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d & mask, exp);
    endtask

    task automatic wait_k(input int n);
        while (k_now() < n) @(negedge clk);
    endtask

    task automatic run_start(input logic [CH_NUM-1:0] en, input int loops, input logic [31:0] ctrl);
        m_on = 1'b0;
        m_ch.delete();
        for (int c = 0; c < CH_NUM; c++) if (en[c]) m_ch.push_back(c);
        m_loops = (loops == 0) ? 1 : loops;
        bus_write(ADDR_CH_EN, 32'(en), 1'b0);
        bus_write(ADDR_LOOPS, 32'(loops), 1'b0);
        bus_write(ADDR_CTRL, ctrl, 1'b1);
    endtask

    localparam logic [31:0] NO_CH = 32'hFFFF_F8FF;

    initial begin
        bus.s_cs = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        bus.s_address = '0; bus.s_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_lb", 32'(lb), 32'd0);
        check("rst_readdata", bus.s_readdata, 32'd0);
`ifdef LB_SCHED_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check_reg("rst_ctrl",    ADDR_CTRL,    32'd0, '1);
        check_reg("rst_ch_en",   ADDR_CH_EN,   32'd0, '1);
        check_reg("rst_loops",   ADDR_LOOPS,   32'd1, '1);
        check_reg("rst_status",  ADDR_STATUS,  32'd0, '1);
        check_reg("rst_ch_fail", ADDR_CH_FAIL, 32'd0, '1);
        check_reg("rst_err_sel", ADDR_ERR_SEL, 32'd0, '1);
        check_reg("rst_err_map", ADDR_ERR_MAP, 32'd0, '1);

        // Pin the schedule model for two channels, one sweep.
        m_ch.delete(); m_ch.push_back(0); m_ch.push_back(1); m_loops = 1;
        check("model_k3",   32'(exp_lb(3)),   32'd0);
        check("model_k4",   32'(exp_lb(4)),   32'd1);
        check("model_k135", 32'(exp_lb(135)), 32'd1);
        check("model_k136", 32'(exp_lb(136)), 32'd0);
        check("model_k140", 32'(exp_lb(140)), 32'd2);
        check("model_k271", 32'(exp_lb(271)), 32'd2);
        check("model_k272", 32'(exp_lb(272)), 32'd0);

        // Both channels, one sweep, no errors.
        run_start(2'b11, 1, 32'h5);
        check_reg("t1_busy_k1", ADDR_STATUS, 32'h0000_0001, NO_CH);
        wait_k(273);
        check_reg("t1_status_k273", ADDR_STATUS, 32'h0000_0001, NO_CH);
        check_reg("t1_status_k274", ADDR_STATUS, 32'h0001_0002, NO_CH);
        check_reg("t1_ch_fail", ADDR_CH_FAIL, 32'd0, '1);
        check_reg("t1_ch_en",   ADDR_CH_EN,   32'd3, '1);

        // Channel 1 only, three sweeps, error during sweep 2.
        err_on = 1'b1;
        run_start(2'b10, 3, 32'h5);
        wait_k(3 * 137 + 2);
        err_on = 1'b0;
        check_reg("t2_status",  ADDR_STATUS,  32'h0003_0006, NO_CH);
        check_reg("t2_ch_fail", ADDR_CH_FAIL, 32'd2, '1);
        bus_write(ADDR_ERR_SEL, 32'd1, 1'b0);
        check_reg("t2_err_sel",  ADDR_ERR_SEL, 32'd1, '1);
        check_reg("t2_err_map1", ADDR_ERR_MAP, 32'h0000_0100, '1);
        bus_write(ADDR_ERR_SEL, 32'd0, 1'b0);
        check_reg("t2_err_map0", ADDR_ERR_MAP, 32'd0, '1);

        // One-cycle synchronous reset in the middle of RUN.
        run_start(2'b10, 1, 32'h1);
        wait_k(60);
        stop_k = 61;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rrst_readdata", bus.s_readdata, 32'd0);
        check("rrst_lb", 32'(lb), 32'd0);
        check_reg("rrst_ch_en",   ADDR_CH_EN,   32'd0, '1);
        check_reg("rrst_loops",   ADDR_LOOPS,   32'd1, '1);
        check_reg("rrst_status",  ADDR_STATUS,  32'd0, '1);
        check_reg("rrst_ch_fail", ADDR_CH_FAIL, 32'd0, '1);
        check_reg("rrst_err_sel", ADDR_ERR_SEL, 32'd0, '1);
        bus_write(ADDR_ERR_SEL, 32'd1, 1'b0);
        check_reg("rrst_err_map1", ADDR_ERR_MAP, 32'd0, '1);

        // Start with no channels enabled.
        run_start(2'b00, 1, 32'h5);
        check_reg("t3_status_k1", ADDR_STATUS, 32'h0000_0002, '1);
        repeat (4) @(negedge clk);

        // Abort 50 cycles into channel 0 RUN, then restart.
        run_start(2'b01, 1, 32'h5);
        wait_k(53);
        stop_k = 54;
        bus_write(ADDR_CTRL, 32'h2, 1'b0);
        check("abort_lb", 32'(lb), 32'd0);
        check_reg("abort_status", ADDR_STATUS, 32'd0, NO_CH);
        run_start(2'b01, 1, 32'h5);
        wait_k(139);
        check_reg("restart_status", ADDR_STATUS, 32'h0001_0002, NO_CH);

`ifdef LB_SCHED_IRQ_EN
        check("irq_disabled", 32'(irq), 32'd0);
        bus_write(ADDR_CTRL, 32'h8, 1'b0);
        check("irq_enabled_pend", 32'(irq), 32'd1);
        bus_write(ADDR_CTRL, 32'hC, 1'b0);
        check("irq_clear", 32'(irq), 32'd0);
        check_reg("irq_ctrl_rd", ADDR_CTRL, 32'h8, '1);
        run_start(2'b01, 1, 32'hD);
        check("irq_busy", 32'(irq), 32'd0);
        wait_k(139);
        check("irq_done", 32'(irq), 32'd1);
        bus_write(ADDR_CTRL, 32'h4, 1'b0);
        check("irq_clear4", 32'(irq), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
